// File: rtl/i2c_target_responder.sv
// I2C target responder: address match, ACK, write-byte delivery, read-byte serialization; optional I2C_GENERAL_CALL_EN.
// Latency: bus events observed SYNC_FF+1 clocks after the pins; RxValid/TxReq one clock after the SCL edge is detected.
// Backpressure: none; the target never stretches SCL, so TxData must be valid in the TxReq cycle.
module i2c_target_responder #(
  parameter logic [6:0] ADDRESS = 7'h42,
  parameter int         SYNC_FF = 2
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic [7:0] TxData,
  output logic       TxReq,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t             state;
  logic [SYNC_FF-1:0] scl_sync;
  logic [SYNC_FF-1:0] sda_sync;
  logic               scl_d;
  logic               sda_d;
  logic [3:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               sda_oe;
  logic               rw;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] in_byte;
  logic       gc_match;
  logic       addr_match;

  // Open-drain: only ever pull low or release.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  assign scl_s     = scl_sync[SYNC_FF-1];
  assign sda_s     = sda_sync[SYNC_FF-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  // Byte as it will look after shifting in the current sample.
  assign in_byte   = {shreg[6:0], sda_s};

`ifdef I2C_GENERAL_CALL_EN
  assign gc_match = (in_byte == 8'h00);
`else
  assign gc_match = 1'b0;
`endif
  assign addr_match = (in_byte[7:1] == ADDRESS) || gc_match;

  // Synchronize SCL/SDA and keep one delayed copy for edge detection; idle bus is high.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_FF-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_FF-2:0], SDA};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Protocol FSM; START/STOP override every state, SDA only moves after SCL falls.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      sda_oe  <= 1'b0;
      rw      <= 1'b0;
      RxData  <= 8'h00;
      RxValid <= 1'b0;
      TxReq   <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      RxValid <= 1'b0;
      TxReq   <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        Busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg <= in_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (addr_match) begin
                  state <= ADDR_ACK;
                  rw    <= sda_s;
                end else begin
                  state <= WAIT_STOP;
                  Busy  <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          // sda_oe doubles as the phase flag: first fall starts the ACK, second ends it.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
                Busy   <= 1'b1;
              end else if (rw) begin
                // Keep SDA low until the fetched byte's MSB replaces it.
                state <= RD_DATA;
                TxReq <= 1'b1;
              end else begin
                state   <= WR_DATA;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shreg <= in_byte;
              if (bit_cnt == 4'd7) begin
                RxData  <= in_byte;
                RxValid <= 1'b1;
                state   <= WR_ACK;
                bit_cnt <= 4'd0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                state   <= WR_DATA;
                bit_cnt <= 4'd0;
              end
            end
          end
          RD_DATA: begin
            if (TxReq) begin
              shreg   <= TxData;
              sda_oe  <= ~TxData[7];
              bit_cnt <= 4'd0;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe  <= ~shreg[6];
                shreg   <= {shreg[6:0], shreg[7]};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          // bit_cnt==8 marks an initiator ACK seen on the 9th rise.
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= WAIT_STOP;
                Busy  <= 1'b0;
              end else begin
                bit_cnt <= 4'd8;
              end
            end else if (scl_fall && (bit_cnt == 4'd8)) begin
              TxReq <= 1'b1;
              state <= RD_DATA;
            end
          end
          IDLE, WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged initiator with open-drain SDA and pull-up.
// Latency: expected bytes queued at stimulus time, compared when RxValid fires or a read byte completes.
// Backpressure: TxData supplied from a queue on the falling clock edge of each TxReq cycle.
module tb_i2c_target_responder;

  localparam time Q = 50ns;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;

  int n_tests = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int rx_extra = 0;
  int overlap = 0;
  int dut_low_cnt = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_rd[$];

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target_responder dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .SCL    (scl),
    .SDA    (sda),
    .RxData (rx_data),
    .RxValid(rx_valid),
    .TxData (tx_data),
    .TxReq  (tx_req),
    .Busy   (busy)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare delivered bytes, serve TxData, watch for illegal outputs.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (exp_rx.size() != 0) check_eq("rx_data", {8'h00, rx_data}, {8'h00, exp_rx.pop_front()});
      else rx_extra++;
    end
    if (tx_req) begin
      tx_cnt++;
      if (tx_q.size() != 0) begin
        tx_data = tx_q.pop_front();
        exp_rd.push_back(tx_data);
      end
    end
    if (rx_valid && tx_req) overlap++;
    if (!sda_low && sda === 1'b0) dut_low_cnt++;
  end

  task automatic send_bit(input logic b);
    #Q sda_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    #Q sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic i2c_start();
    #Q sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q sda_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_low = 1'b1;
    #Q scl = 1'b1;
    #Q sda_low = 1'b0;
    #(2*Q);
  endtask

  task automatic check_read(input string tag, input logic [7:0] got);
    logic [15:0] exp;
    exp = (exp_rd.size() != 0) ? {8'h00, exp_rd.pop_front()} : 16'hdead;
    check_eq(tag, {8'h00, got}, exp);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rx0, tx0, low0;
    logic       gc_ack;
`ifdef I2C_GENERAL_CALL_EN
    gc_ack = 1'b0;
`else
    gc_ack = 1'b1;
`endif

    // Reset state
    #23;
    check_eq("rst_sda", {15'd0, sda}, 16'd1);
    check_eq("rst_rxdata", {8'h00, rx_data}, 16'h0000);
    check_eq("rst_rxvalid", {15'd0, rx_valid}, 16'd0);
    check_eq("rst_txreq", {15'd0, tx_req}, 16'd0);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    rst_n = 1'b1;
    #(4*Q);

    // Write 0x42 + A5
    rx0 = rx_cnt;
    exp_rx.push_back(8'hA5);
    i2c_start();
    send_byte(8'h84, ack);
    check_eq("t1_addr_ack", {15'd0, ack}, 16'd0);
    check_eq("t1_busy", {15'd0, busy}, 16'd1);
    send_byte(8'hA5, ack);
    check_eq("t1_data_ack", {15'd0, ack}, 16'd0);
    i2c_stop();
    check_eq("t1_rx_cnt", 16'(rx_cnt - rx0), 16'd1);
    check_eq("t1_busy_end", {15'd0, busy}, 16'd0);

    // Wrong address: bus never touched by the target
    rx0 = rx_cnt; tx0 = tx_cnt; low0 = dut_low_cnt;
    i2c_start();
    send_byte(8'h86, ack);
    check_eq("t2_addr_ack", {15'd0, ack}, 16'd1);
    send_byte(8'h5C, ack);
    check_eq("t2_data_ack", {15'd0, ack}, 16'd1);
    check_eq("t2_busy", {15'd0, busy}, 16'd0);
    i2c_stop();
    check_eq("t2_sda_low", 16'(dut_low_cnt - low0), 16'd0);
    check_eq("t2_rx_cnt", 16'(rx_cnt - rx0), 16'd0);
    check_eq("t2_tx_cnt", 16'(tx_cnt - tx0), 16'd0);

    // Read two bytes, ACK then NACK
    tx0 = tx_cnt;
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC3);
    i2c_start();
    send_byte(8'h85, ack);
    check_eq("t3_addr_ack", {15'd0, ack}, 16'd0);
    read_byte(d, 1'b0);
    check_read("t3_rd0", d);
    read_byte(d, 1'b1);
    check_read("t3_rd1", d);
    #Q sda_low = 1'b0;
    #Q;
    check_eq("t3_sda_nack", {15'd0, sda}, 16'd1);
    check_eq("t3_busy_nack", {15'd0, busy}, 16'd0);
    check_eq("t3_tx_cnt", 16'(tx_cnt - tx0), 16'd2);
    i2c_stop();

    // Write then repeated START into a read
    rx0 = rx_cnt; tx0 = tx_cnt;
    exp_rx.push_back(8'h11);
    tx_q.push_back(8'h96);
    i2c_start();
    send_byte(8'h84, ack);
    check_eq("t4_addr_ack", {15'd0, ack}, 16'd0);
    send_byte(8'h11, ack);
    check_eq("t4_data_ack", {15'd0, ack}, 16'd0);
    i2c_start();
    send_byte(8'h85, ack);
    check_eq("t4_raddr_ack", {15'd0, ack}, 16'd0);
    read_byte(d, 1'b1);
    check_read("t4_rd", d);
    i2c_stop();
    check_eq("t4_rx_cnt", 16'(rx_cnt - rx0), 16'd1);
    check_eq("t4_tx_cnt", 16'(tx_cnt - tx0), 16'd1);
    check_eq("t4_rxdata", {8'h00, rx_data}, 16'h0011);

    // Reset while the target is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i));
    #Q sda_low = 1'b0;
    #(Q/2);
    check_eq("t5_ack_drv", {15'd0, sda}, 16'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_sda", {15'd0, sda}, 16'd1);
    check_eq("t5_rst_busy", {15'd0, busy}, 16'd0);
    #20 rst_n = 1'b1;
    #(Q/2) scl = 1'b1;
    #(2*Q) scl = 1'b0;
    i2c_start();
    send_byte(8'h84, ack);
    check_eq("t5_readdr_ack", {15'd0, ack}, 16'd0);
    i2c_stop();

    // General call address
    rx0 = rx_cnt;
    if (gc_ack == 1'b0) exp_rx.push_back(8'h5A);
    i2c_start();
    send_byte(8'h00, ack);
    check_eq("t6_gc_ack", {15'd0, ack}, {15'd0, gc_ack});
    send_byte(8'h5A, ack);
    check_eq("t6_gc_data_ack", {15'd0, ack}, {15'd0, gc_ack});
    i2c_stop();
    check_eq("t6_rx_cnt", 16'(rx_cnt - rx0), {15'd0, ~gc_ack});

    #(4*Q);
    check_eq("rx_pending", 16'(exp_rx.size()), 16'd0);
    check_eq("rx_extra", 16'(rx_extra), 16'd0);
    check_eq("rx_tx_overlap", 16'(overlap), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
